// File: rtl/regdump_pkg.sv
// Shared types, default addresses and beat-payload helpers for the register-dump
// store initiator and its bench.
package regdump_pkg;

    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;
    typedef logic [31:0] addr_t;

    localparam addr_t STOP_ADDR     = 32'h0000_0000;
    localparam addr_t TRAP_ADDR     = 32'h0000_0008;
    localparam addr_t INT_DUMP_ADDR = 32'h0000_0010;
    localparam addr_t FP_DUMP_ADDR  = 32'h0000_0018;

    typedef enum logic [1:0] {
        KIND_INT  = 2'd0,
        KIND_FP   = 2'd1,
        KIND_STOP = 2'd2,
        KIND_TRAP = 2'd3
    } beat_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Int registers are dumped as zero-extended 32-bit words.
    function automatic data_t beat_wdata(input beat_kind_e kind, input data_t rdata,
                                         input data_t cause);
        data_t result;
        case (kind)
            KIND_INT:  result = {32'h0000_0000, rdata[31:0]};
            KIND_FP:   result = rdata;
            KIND_TRAP: result = cause;
            default:   result = 64'h0;
        endcase
        return result;
    endfunction

    function automatic strb_t beat_strb(input beat_kind_e kind);
        strb_t result;
        case (kind)
            KIND_INT: result = 8'h0F;
            default:  result = 8'hFF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/regdump_stream_initiator_store_beat_holder.sv
// Holds one store beat (address, data, strobes) and keeps the request raised
// until the arbiter grants it.
module store_beat_holder
    import regdump_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  gnt,
    input  addr_t next_addr,
    input  data_t next_wdata,
    input  strb_t next_strb,
    output logic  req,
    output addr_t addr,
    output data_t wdata,
    output strb_t strb
);

    logic  req_r;
    addr_t addr_r;
    data_t wdata_r;
    strb_t strb_r;

    // Beat capture on load; payload is frozen while the request waits for grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r   <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 64'h0;
            strb_r  <= 8'h00;
        end else if (load) begin
            req_r   <= 1'b1;
            addr_r  <= next_addr;
            wdata_r <= next_wdata;
            strb_r  <= next_strb;
        end else if (req_r && gnt) begin
            req_r   <= 1'b0;
        end
    end

    assign req   = req_r;
    assign addr  = addr_r;
    assign wdata = wdata_r;
    assign strb  = strb_r;

endmodule

// File: rtl/regdump_stream_initiator.sv
// Walks the architectural register file on start and streams it as stores to the
// dump addresses, followed by a stop write; a trap produces a single trap write.
module regdump_stream_initiator
    import regdump_pkg::*;
#(
    parameter int unsigned NUM_INT_REGS  = 31,
    parameter int unsigned NUM_FP_REGS   = 32,
    parameter bit          DUMP_FP       = 1'b1,
    parameter addr_t       ADDR_STOP     = STOP_ADDR,
    parameter addr_t       ADDR_TRAP     = TRAP_ADDR,
    parameter addr_t       ADDR_INT_DUMP = INT_DUMP_ADDR,
    parameter addr_t       ADDR_FP_DUMP  = FP_DUMP_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        trap_i,
    input  logic [63:0] trap_cause_i,
    output logic [4:0]  rf_raddr_o,
    output logic        rf_is_fp_o,
    input  logic [63:0] rf_rdata_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_strb_o,
    output logic        mem_we_o,
    output logic        busy_o,
    output logic        done_o
);

    if ((NUM_INT_REGS < 1) || (NUM_INT_REGS > 31)) begin : g_bad_int_regs
        $error("NUM_INT_REGS must be in 1..31");
    end
    if ((NUM_FP_REGS < 1) || (NUM_FP_REGS > 32)) begin : g_bad_fp_regs
        $error("NUM_FP_REGS must be in 1..32");
    end

    localparam logic [4:0] INT_LAST = 5'(NUM_INT_REGS);
    localparam logic [4:0] FP_LAST  = 5'(NUM_FP_REGS - 1);

    state_e     state_r, state_s;
    beat_kind_e kind_r, kind_s;
    logic [4:0] index_r, index_s;
    data_t      cause_r;
    logic [4:0] rf_raddr_r;
    logic       rf_is_fp_r;
    logic       busy_r;
    logic       done_r;

    logic       load_s;
    logic       beat_req_s;
    logic       beat_done_s;
    addr_t      load_addr_s;

    assign load_s      = (state_r == ST_LOAD);
    assign beat_done_s = beat_req_s && mem_gnt_i;

    // Sequencer: picks the next beat kind/index and state.
    always_comb begin
        state_s = state_r;
        kind_s  = kind_r;
        index_s = index_r;
        case (state_r)
            ST_IDLE: begin
                if (trap_i) begin
                    kind_s  = KIND_TRAP;
                    index_s = 5'd0;
                    state_s = ST_LOAD;
                end else if (start_i) begin
                    kind_s  = KIND_INT;
                    index_s = 5'd1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (beat_done_s) begin
                    case (kind_r)
                        KIND_INT: begin
                            state_s = ST_LOAD;
                            if (index_r < INT_LAST) begin
                                index_s = index_r + 5'd1;
                            end else if (DUMP_FP) begin
                                kind_s  = KIND_FP;
                                index_s = 5'd0;
                            end else begin
                                kind_s  = KIND_STOP;
                                index_s = 5'd0;
                            end
                        end
                        KIND_FP: begin
                            state_s = ST_LOAD;
                            if (index_r < FP_LAST) begin
                                index_s = index_r + 5'd1;
                            end else begin
                                kind_s  = KIND_STOP;
                                index_s = 5'd0;
                            end
                        end
                        KIND_STOP: state_s = ST_DONE;
                        KIND_TRAP: state_s = ST_IDLE;
                        default:   state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Store address for the beat being loaded.
    always_comb begin
        load_addr_s = ADDR_STOP;
        case (kind_r)
            KIND_INT:  load_addr_s = ADDR_INT_DUMP;
            KIND_FP:   load_addr_s = ADDR_FP_DUMP;
            KIND_TRAP: load_addr_s = ADDR_TRAP;
            default:   load_addr_s = ADDR_STOP;
        endcase
    end

    // State, counter and output registers; rf address is registered ahead so it is valid throughout LOAD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            kind_r     <= KIND_INT;
            index_r    <= 5'd0;
            cause_r    <= 64'h0;
            rf_raddr_r <= 5'd0;
            rf_is_fp_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            kind_r     <= kind_s;
            index_r    <= index_s;
            if ((state_r == ST_IDLE) && trap_i) begin
                cause_r <= trap_cause_i;
            end
            rf_raddr_r <= (state_s == ST_LOAD) ? index_s : 5'd0;
            rf_is_fp_r <= (state_s == ST_LOAD) && (kind_s == KIND_FP);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
        end
    end

    store_beat_holder u_holder (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .load       (load_s),
        .gnt        (mem_gnt_i),
        .next_addr  (load_addr_s),
        .next_wdata (beat_wdata(kind_r, rf_rdata_i, cause_r)),
        .next_strb  (beat_strb(kind_r)),
        .req        (beat_req_s),
        .addr       (mem_addr_o),
        .wdata      (mem_wdata_o),
        .strb       (mem_strb_o)
    );

    assign mem_req_o  = beat_req_s;
    assign mem_we_o   = beat_req_s;
    assign rf_raddr_o = rf_raddr_r;
    assign rf_is_fp_o = rf_is_fp_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

endmodule

// File: doc/regdump_stream_initiator.md
Name: regdump_stream_initiator

Overview:
- Synthesizable initiator on the data-memory request port of the tiny SoC.
- On a start pulse, reads the architectural register file and emits the dump/stop store protocol the bench decodes:
  - int regs x1..x31 to 0x10;
  - FP regs f0..f31 to 0x18;
  - a final stop write to 0x0.
- On a trap pulse, emits one trap-signal write to 0x8.
- Sits between the core's debug register-read port and the data-memory arbiter.

Parameters:
NUM_INT_REGS, 31, int registers dumped, starting at x1 (x0 never dumped)
NUM_FP_REGS, 32, FP registers dumped, starting at f0
DUMP_FP, 1, 0 = skip the FP phase entirely
ADDR_STOP, 32'h0, stop-request address
ADDR_TRAP, 32'h8, trap-signal address
ADDR_INT_DUMP, 32'h10, int dump address
ADDR_FP_DUMP, 32'h18, FP dump address

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to begin a full dump
trap_i  in  1  single-cycle trap notification
trap_cause_i  in  64  payload for the trap write, sampled with trap_i
rf_raddr_o  out  5  register-file read index
rf_is_fp_o  out  1  1 = read FP file, 0 = int file
rf_rdata_i  in  64  combinational read data for rf_raddr_o/rf_is_fp_o
mem_req_o  out  1  store request
mem_gnt_i  in  1  grant; a beat completes on req&&gnt at posedge
mem_addr_o  out  32  store address
mem_wdata_o  out  64  store data
mem_strb_o  out  8  byte strobes
mem_we_o  out  1  write enable, always equal to mem_req_o
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse after the stop beat is granted

Behaviour:
- Clock/reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values (asserted immediately, no clock needed): all outputs 0; state IDLE; index counter 0.
- Reset mid-sequence: the sequence is abandoned and no further beats are issued after release.
- FSM states: IDLE, LOAD, ISSUE, DONE.
  - Every beat is LOAD (1 cycle) then ISSUE (at least 1 cycle).
- IDLE:
  - trap_i=1: latch trap_cause_i; beat kind TRAP; go to LOAD.
  - else start_i=1: beat kind INT, index 1; go to LOAD.
  - trap_i and start_i both high: trap wins; start is dropped.
- LOAD:
  - Drive rf_raddr_o = index and rf_is_fp_o = (kind==FP).
  - At the posedge, capture the beat into wdata/addr/strb registers; go to ISSUE.
  - INT beat: wdata = {32'h0, rf_rdata_i[31:0]}, strb 8'h0F, addr ADDR_INT_DUMP.
  - FP beat: wdata = rf_rdata_i, strb 8'hFF, addr ADDR_FP_DUMP.
  - STOP beat: wdata 0, strb 8'hFF, addr ADDR_STOP.
  - TRAP beat: wdata = latched cause, strb 8'hFF, addr ADDR_TRAP.
- ISSUE:
  - mem_req_o = mem_we_o = 1.
  - addr/wdata/strb stay stable until grant.
  - req must not drop before grant.
- On grant (next kind/index):
  - INT with index < NUM_INT_REGS: index+1, stay INT.
  - INT last: go to FP, index 0 if DUMP_FP, else STOP.
  - FP with index < NUM_FP_REGS-1: index+1.
  - FP last: STOP.
  - STOP: go to DONE.
  - TRAP: go to IDLE; done_o is not pulsed.
  - Every transition except STOP→DONE and TRAP→IDLE passes through LOAD.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - start_i sampled at posedge k → mem_req_o high from k+2.
  - With gnt tied high: 2 cycles/beat; 64 beats for the full default dump; done_o at cycle k+129.
- Ignored inputs:
  - start_i or trap_i while busy_o=1 are ignored, not queued.
  - A trap during a dump is dropped.
- Index width: 5 bits, no wrap. NUM_INT_REGS ≤ 31 and NUM_FP_REGS ≤ 32 are checked by elaboration-time asserts.

Decomposition:
- Shared package regdump_pkg holds:
  - data_t (64b), strb_t (8b), addr_t (32b);
  - the four address constants (which the bench imports too);
  - beat_kind_e {INT, FP, STOP, TRAP}.
- One natural sub-module: store_beat_holder, which registers addr/wdata/strb on load and holds req until gnt. The FSM and index counter stay in the top.

Test Plan:
- start pulse, gnt tied 1, rf returns 0xA5A5_0000|idx (int) / 0xDEAD_0000_0000_0000|idx (fp) → 31 writes to 0x10 with wdata 0x0000_0000_A5A5_0001..0x..._001F and strb 0x0F; then 32 writes to 0x18 with 0xDEAD_..._0000..001F; then one write to 0x0 with data 0; done_o at cycle k+129.
- Random gnt stalls (0–5 cycles) → identical beat sequence; addr/wdata/strb unchanged while req&&!gnt; no beat lost or duplicated.
- trap_i with cause 0x2 in IDLE → single write to 0x8, wdata 0x2, strb 0xFF; busy_o low afterwards; done_o never pulses.
- start_i and trap_i in the same cycle → only the trap beat; start pulse mid-dump → no second sequence (exactly 64 beats).
- DUMP_FP=0 → 31 int beats then stop at 0x0; no 0x18 writes.
- rst_ni low during beat 10 while req is high → all outputs 0 asynchronously; after release no req until a new start_i.
